// File: rtl/sad_row_engine_pkg.sv
// Shared block constants, FSM states and pixel helpers for the
// SAD row engine.
package sad_row_engine_pkg;

    localparam int BLK_DIM = 16;
    localparam int PIX_W   = 8;
    localparam int ROW_W   = 128;
    localparam int BLK_W   = 2048;
    localparam int SUM_W   = 12;
    localparam int ACC_W   = 16;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } state_t;

    // Row 0 / col 0 sits in the MSBs of the block bus
    function automatic logic [PIX_W-1:0] blk_pix(
        input logic [BLK_W-1:0] blk,
        input logic [3:0]       r,
        input logic [3:0]       c
    );
        int unsigned lsb;
        lsb = BLK_W - PIX_W * (BLK_DIM * int'(r) + int'(c) + 1);
        return blk[lsb +: PIX_W];
    endfunction

endpackage

// File: rtl/sad_row_engine_if.sv
// Current-block bus, reference row stream and SAD result bundle.
interface sad_row_engine_if
    import sad_row_engine_pkg::*;
#(
    parameter int IDX_W = 9
);
    logic [BLK_W-1:0] cur_blk;
    logic             search_start;
    logic             ref_valid;
    logic [ROW_W-1:0] ref_row;
    logic             ref_ready;
    logic             sad_valid;
    logic [ACC_W-1:0] sad;
    logic [IDX_W-1:0] sad_idx;
    logic [ACC_W-1:0] best_sad;
    logic [IDX_W-1:0] best_idx;
    logic             busy;
    logic             done;

    modport master (
        output cur_blk, search_start, ref_valid, ref_row,
        input  ref_ready, sad_valid, sad, sad_idx,
        input  best_sad, best_idx, busy, done
    );

    modport slave (
        input  cur_blk, search_start, ref_valid, ref_row,
        output ref_ready, sad_valid, sad, sad_idx,
        output best_sad, best_idx, busy, done
    );
endinterface

// File: rtl/sad_row_engine_row16.sv
// Row stage pair: registered absolute differences, then registered
// adder-tree row sum, with valid and tags riding alongside.
module sad_row16
    import sad_row_engine_pkg::*;
#(
    parameter int IDX_W = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_first,
    input  logic             in_last,
    input  logic [IDX_W-1:0] in_idx,
    input  logic [ROW_W-1:0] cur_row,
    input  logic [ROW_W-1:0] ref_row,
    output logic             out_valid,
    output logic             out_first,
    output logic             out_last,
    output logic [IDX_W-1:0] out_idx,
    output logic [SUM_W-1:0] row_sum
);
    logic [PIX_W-1:0] ad   [BLK_DIM];
    logic [PIX_W-1:0] ad_q [BLK_DIM];
    logic             s1_valid;
    logic             s1_first;
    logic             s1_last;
    logic [IDX_W-1:0] s1_idx;
    logic [SUM_W-1:0] sum;

    for (genvar c = 0; c < BLK_DIM; c++) begin : g_ad
        logic [PIX_W-1:0] a;
        logic [PIX_W-1:0] b;
        assign a     = cur_row[ROW_W-PIX_W*(c+1) +: PIX_W];
        assign b     = ref_row[ROW_W-PIX_W*(c+1) +: PIX_W];
        assign ad[c] = (a > b) ? a - b : b - a;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_idx   <= '0;
            for (int c = 0; c < BLK_DIM; c++) ad_q[c] <= '0;
        end else begin
            s1_valid <= in_valid;
            s1_first <= in_first;
            s1_last  <= in_last;
            s1_idx   <= in_idx;
            for (int c = 0; c < BLK_DIM; c++) ad_q[c] <= ad[c];
        end
    end

    always_comb begin
        sum = '0;
        for (int c = 0; c < BLK_DIM; c++) sum = sum + SUM_W'(ad_q[c]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            out_idx   <= '0;
            row_sum   <= '0;
        end else begin
            out_valid <= s1_valid;
            out_first <= s1_first;
            out_last  <= s1_last;
            out_idx   <= s1_idx;
            row_sum   <= sum;
        end
    end
endmodule

// File: rtl/sad_row_engine.sv
// 16x16 SAD engine: row streaming FSM, per-candidate accumulator
// and running-minimum tracker over a full search window.
module sad_row_engine
    import sad_row_engine_pkg::*;
#(
    parameter int NUM_CAND = 289,
    parameter int IDX_W    = 9
) (
    input logic             clk,
    input logic             reset,
    sad_row_engine_if.slave bus
);
    state_t           state;
    state_t           state_nxt;
    logic [3:0]       row_cnt;
    logic [IDX_W-1:0] cand_cnt;
    logic             accept;
    logic             start_ok;
    logic             last_cand;
    logic [ROW_W-1:0] cur_row;

    logic             s2_valid;
    logic             s2_first;
    logic             s2_last;
    logic [IDX_W-1:0] s2_idx;
    logic [SUM_W-1:0] s2_sum;

    logic             s3_valid;
    logic             s3_last;
    logic [IDX_W-1:0] s3_idx;
    logic [ACC_W-1:0] acc;
    logic             fin;
    logic             fin_all;

    logic             sad_valid;
    logic [ACC_W-1:0] sad;
    logic [IDX_W-1:0] sad_idx;
    logic [ACC_W-1:0] best_sad;
    logic [IDX_W-1:0] best_idx;
    logic             done;

    assign accept    = (state == STREAM) && bus.ref_valid;
    assign start_ok  = (state == IDLE) && bus.search_start;
    assign last_cand = (cand_cnt == IDX_W'(NUM_CAND - 1));
    assign fin       = s3_valid && s3_last;
    assign fin_all   = fin && (s3_idx == IDX_W'(NUM_CAND - 1));

    always_comb begin
        cur_row = '0;
        for (int c = 0; c < BLK_DIM; c++)
            cur_row[ROW_W-PIX_W*(c+1) +: PIX_W] =
                blk_pix(bus.cur_blk, row_cnt, 4'(c));
    end

    sad_row16 #(.IDX_W(IDX_W)) u_row (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (accept),
        .in_first  (row_cnt == 4'd0),
        .in_last   (row_cnt == 4'd15),
        .in_idx    (cand_cnt),
        .cur_row   (cur_row),
        .ref_row   (bus.ref_row),
        .out_valid (s2_valid),
        .out_first (s2_first),
        .out_last  (s2_last),
        .out_idx   (s2_idx),
        .row_sum   (s2_sum)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:   if (bus.search_start) state_nxt = STREAM;
            STREAM: if (accept && row_cnt == 4'd15 && last_cand)
                        state_nxt = DRAIN;
            DRAIN:  if (fin_all) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_cnt  <= '0;
            cand_cnt <= '0;
        end else if (start_ok) begin
            row_cnt  <= '0;
            cand_cnt <= '0;
        end else if (accept) begin
            row_cnt <= row_cnt + 4'd1;
            if (row_cnt == 4'd15) cand_cnt <= cand_cnt + 1'b1;
        end
    end

    // A first row reloads so candidates can stream with no gap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s3_valid <= 1'b0;
            s3_last  <= 1'b0;
            s3_idx   <= '0;
            acc      <= '0;
        end else begin
            s3_valid <= s2_valid;
            s3_last  <= s2_valid && s2_last;
            s3_idx   <= s2_idx;
            if (s2_valid)
                acc <= s2_first ? ACC_W'(s2_sum) : acc + ACC_W'(s2_sum);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sad_valid <= 1'b0;
            sad       <= '0;
            sad_idx   <= '0;
            done      <= 1'b0;
        end else begin
            sad_valid <= fin;
            done      <= fin_all;
            if (fin) begin
                sad     <= acc;
                sad_idx <= s3_idx;
            end
        end
    end

    // Strict compare so an equal later candidate never displaces
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            best_sad <= '1;
            best_idx <= '0;
        end else if (start_ok) begin
            best_sad <= '1;
            best_idx <= '0;
        end else if (sad_valid && sad < best_sad) begin
            best_sad <= sad;
            best_idx <= sad_idx;
        end
    end

    assign bus.ref_ready = (state == STREAM);
    assign bus.busy      = (state != IDLE);
    assign bus.sad_valid = sad_valid;
    assign bus.sad       = sad;
    assign bus.sad_idx   = sad_idx;
    assign bus.best_sad  = best_sad;
    assign bus.best_idx  = best_idx;
    assign bus.done      = done;
endmodule
